// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: ID-stage hazard inputs and stall/flush/forward controls.
// The pipeline drives through the master modport; the hazard unit uses slave.
`default_nettype none

interface hazard_stall_unit_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rf_enable;
  logic              id_load_instr;
  logic              ex_jump_taken;
  logic              cu_mux_sel;
  logic              pc_le;
  logic              ifid_le;
  logic              ifid_flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall_active;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rf_enable, id_load_instr, ex_jump_taken,
    input  cu_mux_sel, pc_le, ifid_le, ifid_flush,
           fwd_a_sel, fwd_b_sel, stall_active
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rf_enable, id_load_instr, ex_jump_taken,
    output cu_mux_sel, pc_le, ifid_le, ifid_flush,
           fwd_a_sel, fwd_b_sel, stall_active
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: hazard detection, stall/flush control and operand forwarding select.
// HAZARD_FWD_EN defined: MEM/WB forwarding, load-use stalls only; undefined: stall until producer leaves WB.
`default_nettype none

module hazard_stall_unit #(
  parameter int          REG_AW  = 5,
  parameter int unsigned X0_ADDR = 0
) (
  input  wire                  clk,
  input  wire                  reset,
  hazard_stall_unit_if.slave   hz
);

  localparam logic [REG_AW-1:0] X0       = REG_AW'(X0_ADDR);
  localparam logic [1:0]        FWD_RF   = 2'b00;
  localparam logic [1:0]        FWD_MEM  = 2'b01;
  localparam logic [1:0]        FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_we_q, ex_we_d;
  logic              ex_ld_q, ex_ld_d;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_we_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              wb_we_q;

  function automatic logic match(input logic              used,
                                 input logic              we,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] src);
    return used && we && (rd == src) && (src != X0);
  endfunction

  logic a_ex, b_ex, a_mem, b_mem, a_wb, b_wb;
  logic ld_use, stall_cond, flush, bubble;

  always_comb begin
    a_ex  = match(hz.id_rs1_used, ex_we_q,  ex_rd_q,  hz.id_rs1);
    b_ex  = match(hz.id_rs2_used, ex_we_q,  ex_rd_q,  hz.id_rs2);
    a_mem = match(hz.id_rs1_used, mem_we_q, mem_rd_q, hz.id_rs1);
    b_mem = match(hz.id_rs2_used, mem_we_q, mem_rd_q, hz.id_rs2);
    a_wb  = match(hz.id_rs1_used, wb_we_q,  wb_rd_q,  hz.id_rs1);
    b_wb  = match(hz.id_rs2_used, wb_we_q,  wb_rd_q,  hz.id_rs2);
    ld_use = ex_ld_q && (a_ex || b_ex);
    flush  = hz.ex_jump_taken;
`ifdef HAZARD_FWD_EN
    stall_cond = ld_use;
`else
    stall_cond = ld_use || a_ex || b_ex || a_mem || b_mem || a_wb || b_wb;
`endif
    bubble = flush || stall_cond;
  end

  always_comb begin
    hz.cu_mux_sel   = bubble;
    hz.pc_le        = flush || !stall_cond;
    hz.ifid_le      = flush || !stall_cond;
    hz.ifid_flush   = flush;
    hz.stall_active = stall_cond && !flush;
`ifdef HAZARD_FWD_EN
    // The younger producer (MEM) holds the newer value when both stages match.
    hz.fwd_a_sel = a_mem ? FWD_MEM : (a_wb ? FWD_WB : FWD_RF);
    hz.fwd_b_sel = b_mem ? FWD_MEM : (b_wb ? FWD_WB : FWD_RF);
`else
    hz.fwd_a_sel = FWD_RF;
    hz.fwd_b_sel = FWD_RF;
`endif
  end

  always_comb begin
    ex_rd_d = hz.id_rd;
    ex_we_d = !bubble && hz.id_rf_enable && (hz.id_rd != X0);
    ex_ld_d = !bubble && hz.id_load_instr && (hz.id_rd != X0);
    if (flush)
      state_d = ST_FLUSH;
    else if (stall_cond)
      state_d = ST_STALL;
    else
      state_d = ST_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= ex_rd_q;
      mem_we_q <= ex_we_q;
      wb_rd_q  <= mem_rd_q;
      wb_we_q  <= mem_we_q;
    end
  end

  // Any non-RUN state was entered through a bubble, so EX must hold no producer.
  a_bubble_after_stall: assert property (@(posedge clk) disable iff (reset)
    (state_q != ST_RUN) |-> !(ex_we_q || ex_ld_q));

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench for hazard_stall_unit; expectations follow HAZARD_FWD_EN.
`default_nettype none

module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.REG_AW(5)) hif ();

  hazard_stall_unit #(.REG_AW(5), .X0_ADDR(0)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  // {cu_mux_sel, pc_le, ifid_le, ifid_flush, fwd_a[1:0], fwd_b[1:0], stall_active}
  localparam logic [8:0] RUN = 9'b0_1_1_0_00_00_0;
  localparam logic [8:0] STL = 9'b1_0_0_0_00_00_1;
  localparam logic [8:0] FLS = 9'b1_1_1_1_00_00_0;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  function automatic logic [8:0] run_fwd(input logic [1:0] fa, input logic [1:0] fb);
    return {4'b0110, fa, fb, 1'b0};
  endfunction

  function automatic logic [8:0] observed();
    return {hif.cu_mux_sel, hif.pc_le, hif.ifid_le, hif.ifid_flush,
            hif.fwd_a_sel, hif.fwd_b_sel, hif.stall_active};
  endfunction

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic [4:0] rs1, input bit u1,
                      input logic [4:0] rs2, input bit u2,
                      input logic [4:0] rd, input bit we, input bit ld,
                      input bit jmp, input logic [8:0] exp);
    string      t;
    logic [8:0] e;
    hif.id_rs1        = rs1;
    hif.id_rs1_used   = u1;
    hif.id_rs2        = rs2;
    hif.id_rs2_used   = u2;
    hif.id_rd         = rd;
    hif.id_rf_enable  = we;
    hif.id_load_instr = ld;
    hif.ex_jump_taken = jmp;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq(t, observed(), e);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input string tag, input int n);
    for (int i = 0; i < n; i++)
      step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RUN);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_rs1_used = 1'b0; hif.id_rs2_used = 1'b0;
    hif.id_rd = '0; hif.id_rf_enable = 1'b0; hif.id_load_instr = 1'b0; hif.ex_jump_taken = 1'b0;
    #3;
    check_eq("reset_state", observed(), RUN);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset pulse in the middle of a load-use stall
    step("t1_lw",      5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, RUN);
    step("t1_stall",   5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, STL);
    reset = 1'b1;
    step("t1_in_rst",  5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, RUN);
    reset = 1'b0;
    step("t1_after",   5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, RUN);
    nop("t1_drain", 3);

    // lw x5; add x6,x5,x7
    step("t2_lw",      5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, RUN);
    step("t2_stall",   5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, STL);
`ifdef HAZARD_FWD_EN
    step("t2_fwd_mem", 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, run_fwd(2'b01, 2'b00));
`else
    step("t2_stall2",  5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, STL);
    step("t2_stall3",  5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, STL);
    step("t2_go",      5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, RUN);
`endif
    nop("t2_drain", 3);

    // addi x3; two unrelated; add x4,x3,x3
    step("t3_addi",    5'd0,  1, 5'd0,  0, 5'd3,  1, 0, 0, RUN);
    step("t3_u1",      5'd12, 1, 5'd0,  0, 5'd10, 1, 0, 0, RUN);
    step("t3_u2",      5'd13, 1, 5'd0,  0, 5'd11, 1, 0, 0, RUN);
`ifdef HAZARD_FWD_EN
    step("t3_fwd_wb",  5'd3,  1, 5'd3,  1, 5'd4,  1, 0, 0, run_fwd(2'b10, 2'b10));
`else
    step("t3_stall",   5'd3,  1, 5'd3,  1, 5'd4,  1, 0, 0, STL);
    step("t3_go",      5'd3,  1, 5'd3,  1, 5'd4,  1, 0, 0, RUN);
`endif
    // x3 produced in both MEM and WB
    step("t3_addi_a",  5'd0,  1, 5'd0,  0, 5'd3,  1, 0, 0, RUN);
    step("t3_addi_b",  5'd0,  1, 5'd0,  0, 5'd3,  1, 0, 0, RUN);
    nop("t3_gap", 1);
`ifdef HAZARD_FWD_EN
    step("t3_mem_wins", 5'd3, 1, 5'd3,  1, 5'd4,  1, 0, 0, run_fwd(2'b01, 2'b01));
`else
    step("t3_stall_m", 5'd3,  1, 5'd3,  1, 5'd4,  1, 0, 0, STL);
    step("t3_stall_w", 5'd3,  1, 5'd3,  1, 5'd4,  1, 0, 0, STL);
    step("t3_go2",     5'd3,  1, 5'd3,  1, 5'd4,  1, 0, 0, RUN);
`endif
    nop("t3_drain", 3);

    // x0 is never a hazard source
    step("t4_lw_x0",   5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, RUN);
    step("t4_use_x0",  5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0, RUN);
    step("t4_addi_x0", 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, RUN);
    step("t4_use_x0b", 5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0, RUN);
    nop("t4_drain", 3);

    // Load-use and taken jump together: flush wins
    step("t5_lw",      5'd0, 0, 5'd0, 0, 5'd8,  1, 1, 0, RUN);
    step("t5_flush",   5'd8, 1, 5'd8, 1, 5'd9,  1, 0, 1, FLS);
    step("t5_target",  5'd0, 0, 5'd0, 0, 5'd0,  0, 0, 0, RUN);
`ifdef HAZARD_FWD_EN
    step("t5_fwd_b",   5'd8, 0, 5'd8, 1, 5'd10, 1, 0, 0, run_fwd(2'b00, 2'b10));
`else
    step("t5_stall",   5'd8, 0, 5'd8, 1, 5'd10, 1, 0, 0, STL);
    step("t5_go",      5'd8, 0, 5'd8, 1, 5'd10, 1, 0, 0, RUN);
`endif
    nop("t5_drain", 3);

    // addi x9; add x1,x9,x0
    step("t6_addi",    5'd0, 1, 5'd0, 0, 5'd9, 1, 0, 0, RUN);
`ifdef HAZARD_FWD_EN
    step("t6_no_stall", 5'd9, 1, 5'd0, 1, 5'd1, 1, 0, 0, RUN);
`else
    step("t6_stall1",  5'd9, 1, 5'd0, 1, 5'd1, 1, 0, 0, STL);
    step("t6_stall2",  5'd9, 1, 5'd0, 1, 5'd1, 1, 0, 0, STL);
    step("t6_stall3",  5'd9, 1, 5'd0, 1, 5'd1, 1, 0, 0, STL);
    step("t6_go",      5'd9, 1, 5'd0, 1, 5'd1, 1, 0, 0, RUN);
`endif
    nop("t6_drain", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
